dz_scan: RTL and testbench
==========================

DZ_SCAN -- requirements
Module: dz_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 1000, giving clk cycles per row slot; legal range 2..65535.
REQ-002 The module SHALL have parameter BLINK_FRAMES, default 32, giving frames per blink half-period; legal range 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 Port dst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port num, input, 4 bits: image index selected by the upstream transfer stage.
REQ-006 Port fail, input, 1 bit: colour select; 1 selects green, 0 selects red.
REQ-007 Port row, output, 8 bits: active-low one-hot row drive; row[i] low means matrix row i is lit.
REQ-008 Port colg, output, 8 bits: active-high green column data; bit 7 is the leftmost column.
REQ-009 Port colr, output, 8 bits: active-high red column data; bit 7 is the leftmost column.

Function
REQ-010 A divider counter div SHALL count 0..SCAN_DIV-1 and wrap to 0; the terminal count is div==SCAN_DIV-1.
REQ-011 A 3-bit row index ridx SHALL increment on each terminal count and wrap from 7 to 0.
REQ-012 A frame SHALL be 8 row slots, i.e. 8*SCAN_DIV cycles.
REQ-013 On the terminal count with ridx==7 (frame boundary), num and fail SHALL be latched into img and col_sel.
REQ-014 num and fail SHALL NOT affect the outputs between frame boundaries; this prevents tearing.
REQ-015 The image ROM SHALL hold 8 bytes per index.
REQ-016 ROM indices 0..9 SHALL hold the team image table patterns.
REQ-017 ROM indices 10..13 SHALL be all-zero.
REQ-018 ROM index 14 SHALL be blank (all zero).
REQ-019 ROM index 15 SHALL be the all-on test pattern (8'hFF in every row).
REQ-020 Outputs SHALL be registered and SHALL reflect ridx and div with 1 cycle of latency.
REQ-021 Dead time: while div==0, row SHALL be 8'hFF and colg and colr SHALL be 8'h00, giving anti-ghosting blanking.
REQ-022 While div!=0, row SHALL equal ~(8'b1<<ridx).
REQ-023 While div!=0 and col_sel==1: colg SHALL equal ROM[img][ridx] and colr SHALL be 0.
REQ-024 While div!=0 and col_sel==0: colr SHALL equal ROM[img][ridx] and colg SHALL be 0.
REQ-025 colg and colr SHALL never both be nonzero in the same cycle.
REQ-026 A num change that coincides with the frame-boundary cycle SHALL be captured at that boundary.

Reset
REQ-027 While dst is low, outputs SHALL be: row=8'hFF, colg=8'h00, colr=8'h00.
REQ-028 While dst is low, internal state SHALL be: div=0, ridx=0, img=14, col_sel=0, blink phase=on, frame counter=0.
REQ-029 Reset asserted mid-frame SHALL force the reset values immediately, without waiting for a clock edge.
REQ-030 After dst deasserts, the first frame SHALL display blank until the first frame boundary latches num.

Configuration
REQ-031 With macro DZ_SCAN_BLINK_EN defined, a frame counter SHALL count frame boundaries and toggle blink phase every BLINK_FRAMES frames.
REQ-032 With DZ_SCAN_BLINK_EN defined, while col_sel==1 and blink phase is off, colg SHALL be 0 and row SHALL be 8'hFF.
REQ-033 With DZ_SCAN_BLINK_EN defined, the frame counter and blink phase SHALL reset to 0 and on when col_sel goes 0 to 1.
REQ-034 With DZ_SCAN_BLINK_EN defined, red display (col_sel==0) SHALL never blink.
REQ-035 Without DZ_SCAN_BLINK_EN, green display SHALL be steady and no frame counter or blink logic SHALL be synthesised.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-036 Scenario: dst low, then high, num=15, fail=0 -> frame 0 row=FF and colr=00 throughout; from frame 1, row cycles FE,FD,...,7F with colr=FF, 3 of every 4 cycles, and colg=00.
REQ-037 Scenario: num=15, fail=1 -> after the next boundary, colg=FF and colr=00 in lit cycles, and row=FF whenever div==0.
REQ-038 Scenario: num changes 15 to 14 mid-frame at ridx=3 -> rows 3..7 still show FF; the next frame shows 00 in all rows.
REQ-039 Scenario: num=15, fail=1, DZ_SCAN_BLINK_EN defined -> frames alternate 2 lit and 2 dark (row=FF, colg=00); without the macro, all frames are lit.
REQ-040 Scenario: dst pulsed low at ridx=5, div=2 -> row=FF, colg=00 and colr=00 asynchronously; after release, scan restarts at ridx=0 with a blank frame.

Source files
------------

// File: rtl/dz_scan.sv
// 8x8 bicolour dot-matrix row scanner with per-frame image/colour latching and row dead time.
// Optional green blink is enabled by defining DZ_SCAN_BLINK_EN.
module dz_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       dst,
  input  logic [3:0] num,
  input  logic       fail,
  output logic [7:0] row,
  output logic [7:0] colg,
  output logic [7:0] colr
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || SCAN_DIV > 65535 || BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_params
    $error("dz_scan: SCAN_DIV or BLINK_FRAMES out of range");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       ridx_q, ridx_d;
  logic [3:0]       img_q, img_d;
  logic             col_sel_q, col_sel_d;
  logic             started_q, started_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       colg_q, colg_d;
  logic [7:0]       colr_q, colr_d;
`ifdef DZ_SCAN_BLINK_EN
  logic [7:0]       fcnt_q, fcnt_d;
  logic             blink_on_q, blink_on_d;
`endif

  logic       term;
  logic       frame_end;
  logic       lit;
  logic [7:0] row_sel;
  logic [7:0] rom_byte;

  // Row r of an image sits in bits [8r+7:8r]; bit 7 of each byte is the leftmost column.
  function automatic logic [7:0] rom_row(input logic [3:0] idx, input logic [2:0] r);
    logic [63:0] pat;
    case (idx)
      4'd0:    pat = 64'h003C6666766E663C;
      4'd1:    pat = 64'h007E181818183818;
      4'd2:    pat = 64'h007E60300C06663C;
      4'd3:    pat = 64'h003C66061C06663C;
      4'd4:    pat = 64'h000C0C7E6C3C1C0C;
      4'd5:    pat = 64'h003C6606067C607E;
      4'd6:    pat = 64'h003C6666667C603C;
      4'd7:    pat = 64'h00303030180C067E;
      4'd8:    pat = 64'h003C66663C66663C;
      4'd9:    pat = 64'h00380C063E66663C;
      4'd15:   pat = 64'hFFFFFFFFFFFFFFFF;
      default: pat = 64'h0000000000000000;
    endcase
    return pat[{r, 3'b000} +: 8];
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_row_sel
    assign row_sel[gi] = (ridx_q == 3'(gi));
  end

  assign rom_byte = rom_row(img_q, ridx_q);

  always_comb begin
    term      = (div_q == DIV_LAST);
    frame_end = term && (ridx_q == 3'd7);
    div_d     = term ? '0 : div_q + 1'b1;
    ridx_d    = term ? ridx_q + 3'd1 : ridx_q;
    img_d     = frame_end ? num : img_q;
    col_sel_d = frame_end ? fail : col_sel_q;
    // Nothing is lit until the first boundary has latched a real selection.
    started_d = started_q | frame_end;

`ifdef DZ_SCAN_BLINK_EN
    fcnt_d     = fcnt_q;
    blink_on_d = blink_on_q;
    if (frame_end) begin
      if (fail && !col_sel_q) begin
        fcnt_d     = 8'd0;
        blink_on_d = 1'b1;
      end else if (fcnt_q == 8'(BLINK_FRAMES - 1)) begin
        fcnt_d     = 8'd0;
        blink_on_d = ~blink_on_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
    lit = started_q && (div_q != '0) && (!col_sel_q || blink_on_q);
`else
    lit = started_q && (div_q != '0);
`endif

    row_d  = lit ? ~row_sel : 8'hFF;
    colg_d = (lit && col_sel_q)  ? rom_byte : 8'h00;
    colr_d = (lit && !col_sel_q) ? rom_byte : 8'h00;
  end

  always_ff @(posedge clk or negedge dst) begin
    if (!dst) begin
      div_q      <= '0;
      ridx_q     <= 3'd0;
      img_q      <= 4'd14;
      col_sel_q  <= 1'b0;
      started_q  <= 1'b0;
      row_q      <= 8'hFF;
      colg_q     <= 8'h00;
      colr_q     <= 8'h00;
`ifdef DZ_SCAN_BLINK_EN
      fcnt_q     <= 8'd0;
      blink_on_q <= 1'b1;
`endif
    end else begin
      div_q      <= div_d;
      ridx_q     <= ridx_d;
      img_q      <= img_d;
      col_sel_q  <= col_sel_d;
      started_q  <= started_d;
      row_q      <= row_d;
      colg_q     <= colg_d;
      colr_q     <= colr_d;
`ifdef DZ_SCAN_BLINK_EN
      fcnt_q     <= fcnt_d;
      blink_on_q <= blink_on_d;
`endif
    end
  end

  assign row  = row_q;
  assign colg = colg_q;
  assign colr = colr_q;

endmodule

// File: tb/tb_dz_scan.sv
// Directed bench for dz_scan with SCAN_DIV=4, BLINK_FRAMES=2.
// n counts rising edges since reset release; outputs sampled at the following falling edge.
module tb_dz_scan;

  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk  = 1'b0;
  logic       dst  = 1'b1;
  logic [3:0] num  = 4'd15;
  logic       fail = 1'b0;
  logic [7:0] row, colg, colr;

  int tests_run    = 0;
  int tests_failed = 0;
  int n            = 0;

  dz_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk  (clk),
    .dst  (dst),
    .num  (num),
    .fail (fail),
    .row  (row),
    .colg (colg),
    .colr (colr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  // Output sampled after edge k shows the scan state that held before edge k.
  function automatic int dv(int k);
    return (k - 1) % SD;
  endfunction

  function automatic int rx(int k);
    return ((k - 1) / SD) % 8;
  endfunction

  function automatic int frm(int k);
    return (k - 1) / (8 * SD);
  endfunction

  function automatic logic [7:0] scan_row(int k);
    return (dv(k) == 0) ? 8'hFF : ~(8'h01 << rx(k));
  endfunction

  function automatic logic [7:0] lit_col(int k, logic [7:0] pat);
    return (dv(k) == 0) ? 8'h00 : pat;
  endfunction

  task automatic test_reset();
    #2 dst = 1'b0;
    #1;
    tests_run++;
    if ({row, colg, colr} !== {8'hFF, 8'h00, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_async got row=%h colg=%h colr=%h want row=ff colg=00 colr=00", row, colg, colr);
    end
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if ({row, colg, colr} !== {8'hFF, 8'h00, 8'h00}) begin
        tests_failed++;
        $display("FAIL reset_hold got row=%h colg=%h colr=%h want row=ff colg=00 colr=00", row, colg, colr);
      end
    end
    $display("[TB] test_reset done, %0d checks so far", tests_run);
  endtask

  task automatic test_red_full();
    logic [7:0] er, eg, ecr;
    num  = 4'd15;
    fail = 1'b0;
    dst  = 1'b1;
    n    = 0;
    repeat (64) begin
      tick();
      eg = 8'h00;
      if (frm(n) == 0) begin
        er  = 8'hFF;
        ecr = 8'h00;
      end else begin
        er  = scan_row(n);
        ecr = lit_col(n, 8'hFF);
      end
      tests_run++;
      if ({row, colg, colr} !== {er, eg, ecr}) begin
        tests_failed++;
        $display("FAIL red_full n=%0d got row=%h colg=%h colr=%h want row=%h colg=%h colr=%h", n, row, colg, colr, er, eg, ecr);
      end
    end
    $display("[TB] test_red_full done, %0d checks so far", tests_run);
  endtask

  task automatic test_tearing();
    logic [7:0] er, eg, ecr;
    while (n < 127) begin
      tick();
      er  = scan_row(n);
      eg  = 8'h00;
      ecr = (frm(n) == 2) ? lit_col(n, 8'hFF) : 8'h00;
      tests_run++;
      if ({row, colg, colr} !== {er, eg, ecr}) begin
        tests_failed++;
        $display("FAIL tearing n=%0d got row=%h colg=%h colr=%h want row=%h colg=%h colr=%h", n, row, colg, colr, er, eg, ecr);
      end
      if (n == 76) num = 4'd14;
    end
    $display("[TB] test_tearing done, %0d checks so far", tests_run);
  endtask

  // Inputs change during the boundary cycle itself and must be taken at that boundary.
  task automatic test_green();
    logic [7:0] er, eg, ecr;
    num  = 4'd15;
    fail = 1'b1;
    while (n < 160) begin
      tick();
      er  = scan_row(n);
      ecr = 8'h00;
      eg  = (frm(n) == 3) ? 8'h00 : lit_col(n, 8'hFF);
      tests_run++;
      if ({row, colg, colr} !== {er, eg, ecr}) begin
        tests_failed++;
        $display("FAIL green n=%0d got row=%h colg=%h colr=%h want row=%h colg=%h colr=%h", n, row, colg, colr, er, eg, ecr);
      end
    end
    $display("[TB] test_green done, %0d checks so far", tests_run);
  endtask

  task automatic test_blink();
    logic [7:0] er, eg, ecr;
    logic       on;
    while (n < 288) begin
      tick();
`ifdef DZ_SCAN_BLINK_EN
      on = ((frm(n) - 4) % 4) < 2;
`else
      on = 1'b1;
`endif
      ecr = 8'h00;
      if (on) begin
        er = scan_row(n);
        eg = lit_col(n, 8'hFF);
      end else begin
        er = 8'hFF;
        eg = 8'h00;
      end
      tests_run++;
      if ({row, colg, colr} !== {er, eg, ecr}) begin
        tests_failed++;
        $display("FAIL blink n=%0d got row=%h colg=%h colr=%h want row=%h colg=%h colr=%h", n, row, colg, colr, er, eg, ecr);
      end
      if (n == 287) fail = 1'b0;
    end
    $display("[TB] test_blink done, %0d checks so far", tests_run);
  endtask

  task automatic test_red_steady();
    logic [7:0] er, ecr;
    while (n < 384) begin
      tick();
      er  = scan_row(n);
      ecr = lit_col(n, 8'hFF);
      tests_run++;
      if ({row, colg, colr} !== {er, 8'h00, ecr}) begin
        tests_failed++;
        $display("FAIL red_steady n=%0d got row=%h colg=%h colr=%h want row=%h colg=00 colr=%h", n, row, colg, colr, er, ecr);
      end
      if (n == 383) num = 4'd10;
    end
    $display("[TB] test_red_steady done, %0d checks so far", tests_run);
  endtask

  task automatic test_zero_index();
    logic [7:0] er;
    while (n < 416) begin
      tick();
      er = scan_row(n);
      tests_run++;
      if ({row, colg, colr} !== {er, 8'h00, 8'h00}) begin
        tests_failed++;
        $display("FAIL zero_index n=%0d got row=%h colg=%h colr=%h want row=%h colg=00 colr=00", n, row, colg, colr, er);
      end
      if (n == 415) num = 4'd15;
    end
    $display("[TB] test_zero_index done, %0d checks so far", tests_run);
  endtask

  task automatic test_async_reset();
    logic [7:0] er, ecr;
    // Stop with the scan state at ridx=5, div=2.
    while (n < 438) begin
      tick();
      er  = scan_row(n);
      ecr = lit_col(n, 8'hFF);
      tests_run++;
      if ({row, colg, colr} !== {er, 8'h00, ecr}) begin
        tests_failed++;
        $display("FAIL pre_reset n=%0d got row=%h colg=%h colr=%h want row=%h colg=00 colr=%h", n, row, colg, colr, er, ecr);
      end
    end
    #2 dst = 1'b0;
    #1;
    tests_run++;
    if ({row, colg, colr} !== {8'hFF, 8'h00, 8'h00}) begin
      tests_failed++;
      $display("FAIL midframe_reset got row=%h colg=%h colr=%h want row=ff colg=00 colr=00", row, colg, colr);
    end
    @(negedge clk);
    tests_run++;
    if ({row, colg, colr} !== {8'hFF, 8'h00, 8'h00}) begin
      tests_failed++;
      $display("FAIL midframe_reset_hold got row=%h colg=%h colr=%h want row=ff colg=00 colr=00", row, colg, colr);
    end
    dst = 1'b1;
    n   = 0;
    repeat (64) begin
      tick();
      if (frm(n) == 0) begin
        er  = 8'hFF;
        ecr = 8'h00;
      end else begin
        er  = scan_row(n);
        ecr = lit_col(n, 8'hFF);
      end
      tests_run++;
      if ({row, colg, colr} !== {er, 8'h00, ecr}) begin
        tests_failed++;
        $display("FAIL restart n=%0d got row=%h colg=%h colr=%h want row=%h colg=00 colr=%h", n, row, colg, colr, er, ecr);
      end
    end
    $display("[TB] test_async_reset done, %0d checks so far", tests_run);
  endtask

  initial begin
    test_reset();
    test_red_full();
    test_tearing();
    test_green();
    test_blink();
    test_red_steady();
    test_zero_index();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
